mem_scan_ctrl: RTL and testbench

MEM_SCAN_CTRL -- requirements
Module: mem_scan_ctrl

---
 rtl/mem_scan_pkg.sv | 18 +
 rtl/msc_ram.sv | 29 ++
 rtl/mem_scan_ctrl.sv | 143 ++++++++++++++
 tb/tb_mem_scan_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_scan_pkg.sv
// Shared types for the memory scan controller: operating-mode encoding and FSM states.
package mem_scan_pkg;

    typedef enum logic [1:0] {
        ModeAuto  = 2'b00,
        ModeStep  = 2'b01,
        ModeWrite = 2'b10,
        ModeHold  = 2'b11
    } msc_mode_e;

    typedef enum logic [1:0] {
        StIdle,
        StWr,
        StAdv,
        StRd
    } msc_state_e;

endpackage

// File: rtl/msc_ram.sv
// Single-port synchronous RAM with one-cycle read latency; contents are never reset.
module msc_ram #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_scan_ctrl.sv
// Memory scan controller: steps an address through a RAM in AUTO/STEP/WRITE/HOLD modes.
// Define MSC_CHECKSUM_EN to enable the per-sweep checksum; otherwise checksum reads 0.
module mem_scan_ctrl
    import mem_scan_pkg::*;
#(
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic              CLOCK_50,
    input  logic              Resetn,
    input  logic [1:0]        mode,
    input  logic              step,
    input  logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              wrap,
    output logic [DATA_W-1:0] checksum
);

    localparam int unsigned       CntW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CntW-1:0]   CntMax  = CntW'(TICK_DIV - 1);
    localparam logic [ADDR_W-1:0] AddrMax = '1;

    msc_state_e        state_q, state_d;
    msc_mode_e         mode_in;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              tick;
    logic              step_q, step_rise;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wrap_q, wrap_d;
    logic              rd_pend_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;
    logic              ram_en, ram_we;
    logic [DATA_W-1:0] ram_rdata;

    assign mode_in   = msc_mode_e'(mode);
    assign step_rise = step & ~step_q;
    assign tick      = (cnt_q == CntMax);
    assign cnt_d     = tick ? '0 : cnt_q + CntW'(1);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wrap_d  = 1'b0;
        ram_en  = 1'b0;
        ram_we  = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Mode is only looked at here, so mid-sequence changes wait for the next IDLE.
                unique case (mode_in)
                    ModeAuto:  if (tick)      state_d = StAdv;
                    ModeStep:  if (step_rise) state_d = StAdv;
                    ModeWrite: if (step_rise) state_d = StWr;
                    ModeHold:  ;
                endcase
            end
            StWr: begin
                ram_en  = 1'b1;
                ram_we  = 1'b1;
                state_d = StAdv;
            end
            StAdv: begin
                addr_d  = addr_q + 1'b1;
                wrap_d  = (addr_q == AddrMax);
                state_d = StRd;
            end
            StRd: begin
                ram_en  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            step_q     <= 1'b0;
            addr_q     <= '0;
            wrap_q     <= 1'b0;
            rd_pend_q  <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            step_q     <= step;
            addr_q     <= addr_d;
            wrap_q     <= wrap_d;
            // RAM output is valid the cycle after RD; capture it then.
            rd_pend_q  <= (state_q == StRd);
            rd_valid_q <= rd_pend_q;
            if (rd_pend_q) begin
                rd_data_q <= ram_rdata;
            end
        end
    end

`ifdef MSC_CHECKSUM_EN
    logic [DATA_W-1:0] acc_q, cks_q;

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            acc_q <= '0;
            cks_q <= '0;
        end else if (rd_pend_q) begin
            // addr_q still holds the address just read; it cannot move before this edge.
            if (addr_q == AddrMax) begin
                cks_q <= acc_q + ram_rdata;
                acc_q <= '0;
            end else begin
                acc_q <= acc_q + ram_rdata;
            end
        end
    end

    assign checksum = cks_q;
`else
    assign checksum = '0;
`endif

    msc_ram #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_ram (
        .clk_i  (CLOCK_50),
        .en_i   (ram_en),
        .we_i   (ram_we),
        .addr_i (addr_q),
        .wdata_i(wr_data),
        .rdata_o(ram_rdata)
    );

    assign addr     = addr_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign wrap     = wrap_q;

endmodule

// File: tb/tb_mem_scan_ctrl.sv
// Scoreboard bench for mem_scan_ctrl (ADDR_W=3, DATA_W=8, TICK_DIV=4) with a reference model.
module tb_mem_scan_ctrl;

    localparam logic [1:0] MODE_AUTO  = 2'b00;
    localparam logic [1:0] MODE_STEP  = 2'b01;
    localparam logic [1:0] MODE_WRITE = 2'b10;
    localparam logic [1:0] MODE_HOLD  = 2'b11;

    logic       clk = 1'b0;
    logic       Resetn;
    logic [1:0] mode;
    logic       step;
    logic [7:0] wr_data;
    logic [2:0] addr;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       wrap;
    logic [7:0] checksum;

    mem_scan_ctrl #(
        .ADDR_W  (3),
        .DATA_W  (8),
        .TICK_DIV(4)
    ) dut (
        .CLOCK_50(clk),
        .Resetn  (Resetn),
        .mode    (mode),
        .step    (step),
        .wr_data (wr_data),
        .addr    (addr),
        .rd_data (rd_data),
        .rd_valid(rd_valid),
        .wrap    (wrap),
        .checksum(checksum)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] addr;
        logic [7:0] data;
        bit         dknown;
        logic [7:0] cks;
        bit         cknown;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   errors   = 0;
    int   wrap_cnt = 0;
    int   cyc      = 0;

    // Reference model: memory image, current address, sweep accumulator.
    logic [7:0] mem [8];
    bit         known [8];
    logic [2:0] m_addr;
    logic [7:0] m_acc, m_cks;
    bit         m_acc_known, m_cks_known;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_addr      = 3'd0;
        m_acc       = 8'd0;
        m_acc_known = 1'b1;
        m_cks       = 8'd0;
        m_cks_known = 1'b1;
    endtask

    // One advance: optional write at the current address, then read of the next one.
    task automatic model_adv(input logic [1:0] m, input logic [7:0] d);
        exp_t e;
        if (m == MODE_WRITE) begin
            mem[m_addr]   = d;
            known[m_addr] = 1'b1;
        end
        m_addr   = m_addr + 3'd1;
        e.addr   = m_addr;
        e.data   = mem[m_addr];
        e.dknown = known[m_addr];
`ifdef MSC_CHECKSUM_EN
        if (m_addr == 3'd7) begin
            m_cks       = m_acc + e.data;
            m_cks_known = m_acc_known && e.dknown;
            m_acc       = 8'd0;
            m_acc_known = 1'b1;
        end else begin
            m_acc       = m_acc + e.data;
            m_acc_known = m_acc_known && e.dknown;
        end
`endif
        e.cks    = m_cks;
        e.cknown = m_cks_known;
        sb.push_back(e);
    endtask

    always @(posedge clk) cyc++;

    // Monitor: every rd_valid pulse must match the oldest expected read.
    always @(negedge clk) begin
        exp_t e;
        if (Resetn) begin
            if (wrap) wrap_cnt++;
            if (rd_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_valid_unexpected: got pulse at addr %0d expected none", addr);
                end else begin
                    e = sb.pop_front();
                    check("rd_addr", 32'(addr), 32'(e.addr));
                    if (e.dknown) check("rd_data", 32'(rd_data), 32'(e.data));
                    if (e.cknown) check("checksum", 32'(checksum), 32'(e.cks));
                end
            end
        end
    end

    task automatic chk_reset_state();
        check("rst_addr", 32'(addr), 0);
        check("rst_rd_data", 32'(rd_data), 0);
        check("rst_rd_valid", 32'(rd_valid), 0);
        check("rst_wrap", 32'(wrap), 0);
        check("rst_checksum", 32'(checksum), 0);
    endtask

    // Drive one step-edge operation with step held for 'hold' cycles; checks latency.
    task automatic fire(input logic [1:0] m, input logic [7:0] d, input int hold);
        int  k;
        int  lat;
        int  len;
        bit  got;
        @(negedge clk);
        mode    = m;
        wr_data = d;
        step    = 1'b1;
        if (m != MODE_HOLD) model_adv(m, d);
        lat = (m == MODE_WRITE) ? 4 : 3;
        len = (hold > 8) ? hold : 8;
        got = 1'b0;
        k   = 99;
        @(posedge clk);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            if (!got && rd_valid) begin
                got = 1'b1;
                k   = i;
            end
            if (i == hold - 1) step = 1'b0;
        end
        if (m == MODE_HOLD) check("hold_no_read", 32'(got), 0);
        else check("latency", k, lat);
        check("addr", 32'(addr), 32'(m_addr));
    endtask

    task automatic auto_run(input int n);
        int         last;
        int         w0;
        int         wraps_exp;
        int         c;
        logic [2:0] nxt;
        w0        = wrap_cnt;
        wraps_exp = 0;
        last      = 0;
        @(negedge clk);
        mode = MODE_AUTO;
        for (int j = 0; j < n; j++) begin
            c = 0;
            while (addr == m_addr && c < 12) begin
                @(negedge clk);
                c++;
            end
            nxt = m_addr + 3'd1;
            check("auto_advance", 32'(addr), 32'(nxt));
            if (addr != nxt) begin
                mode = MODE_HOLD;
                return;
            end
            if (j > 0) check("auto_period", cyc - last, 4);
            last = cyc;
            if (m_addr == 3'd7) wraps_exp++;
            model_adv(MODE_AUTO, 8'h00);
        end
        mode = MODE_HOLD;
        repeat (12) @(negedge clk);
        check("hold_addr", 32'(addr), 32'(m_addr));
        check("wrap_count", wrap_cnt - w0, wraps_exp);
    endtask

    // A second step edge lands in RD (STEP) or ADV (WRITE) and must be dropped.
    task automatic busy_drop(input logic [1:0] m);
        @(negedge clk);
        mode    = m;
        wr_data = 8'($urandom);
        step    = 1'b1;
        model_adv(m, wr_data);
        @(posedge clk);
        @(negedge clk);
        step = 1'b0;
        @(negedge clk);
        step = 1'b1;
        repeat (3) @(negedge clk);
        step = 1'b0;
        repeat (8) @(negedge clk);
        check("busy_addr", 32'(addr), 32'(m_addr));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        int         r;
        Resetn  = 1'b0;
        mode    = MODE_HOLD;
        step    = 1'b0;
        wr_data = 8'h00;
        for (int i = 0; i < 8; i++) known[i] = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk_reset_state();
        Resetn = 1'b1;

        for (int i = 0; i < 8; i++) fire(MODE_WRITE, 8'(i + 1), 1 + int'($urandom % 3));

        auto_run(16);
`ifdef MSC_CHECKSUM_EN
        check("checksum_sweep", 32'(checksum), 32'h24);
`else
        check("checksum_off", 32'(checksum), 0);
`endif

        fire(MODE_WRITE, 8'hA5, 2);
        for (int i = 0; i < 8; i++) fire(MODE_STEP, 8'h00, int'($urandom_range(1, 4)));

        fire(MODE_STEP, 8'h00, 10);

        busy_drop(MODE_STEP);
        busy_drop(MODE_WRITE);

        for (int i = 0; i < 24; i++) begin
            r = int'($urandom % 3);
            d = 8'($urandom);
            case (r)
                0:       fire(MODE_STEP, d, int'($urandom_range(1, 10)));
                1:       fire(MODE_WRITE, d, int'($urandom_range(1, 10)));
                default: fire(MODE_HOLD, d, int'($urandom_range(1, 10)));
            endcase
        end

        // Mid-sweep asynchronous reset at address 5.
        while (m_addr != 3'd5) fire(MODE_STEP, 8'h00, 1);
        @(negedge clk);
        #1 Resetn = 1'b0;
        #1 chk_reset_state();
        model_reset();
        repeat (2) @(negedge clk);
        Resetn = 1'b1;

        // Reset between the WRITE event and the WR edge must suppress the write.
        fire(MODE_STEP, 8'h00, 1);
        fire(MODE_STEP, 8'h00, 1);
        @(negedge clk);
        mode    = MODE_WRITE;
        wr_data = ~mem[m_addr];
        step    = 1'b1;
        @(posedge clk);
        #2 Resetn = 1'b0;
        step = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        Resetn = 1'b1;
        fire(MODE_STEP, 8'h00, 1);
        fire(MODE_STEP, 8'h00, 2);

        repeat (10) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
